// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types for the multi-cycle integer divider
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_BUSY   = 2'b10,
        DIV_DONE   = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider producing {remainder, quotient}
// for DIV/DIVU, one quotient bit per cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? neg(v) : v;
    endfunction

    div_state_e         state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] fixed;

    // quo_q starts as |dividend| and fills with quotient bits from the right
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fixed   = {neg_rem_q ? neg(rem_q) : rem_q, neg_quo_q ? neg(quo_q) : quo_q};
    assign result  = (state_q == DIV_DONE && !annul) ? fixed : result_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready     = 1'b0;
        busy      = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (start && !annul) begin
                    busy = 1'b1;
                    if (opdata2 != '0) begin
                        state_d   = DIV_BUSY;
                        rem_d     = '0;
                        quo_d     = abs_val(opdata1, signed_div);
                        dvs_d     = abs_val(opdata2, signed_div);
                        cnt_d     = '0;
                        neg_quo_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        neg_rem_d = signed_div & opdata1[WIDTH-1];
                    end else begin
                        state_d = DIV_BYZERO;
                    end
                end
            end
            DIV_BYZERO: begin
                // Zero the datapath so the DONE fix-up yields a clean 0 result
                busy      = 1'b1;
                rem_d     = '0;
                quo_d     = '0;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
                state_d   = DIV_DONE;
            end
            DIV_BUSY: begin
                busy = 1'b1;
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                ready    = 1'b1;
                result_d = fixed;
                state_d  = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase

        if (annul) begin
            state_d  = DIV_IDLE;
            ready    = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DIV_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with directed vectors
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [63:0] last_res;

    typedef struct {
        logic [63:0] res;
        int          at;
        string       name;
    } exp_t;
    exp_t sb[$];

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn === 1'b1 && ready === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: cycle %0d result %h, required no ready", cyc, result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                tests++;
                if (result !== e.res) begin
                    fails++;
                    $display("FAIL %s_result: got %h required %h", e.name, result, e.res);
                end
                tests++;
                if (cyc != e.at) begin
                    fails++;
                    $display("FAIL %s_latency: ready at cycle %0d required %0d", e.name, cyc, e.at);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic run_op(input string name, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        exp_t e;
        int   bad;
        bad        = 0;
        start      = 1'b1;
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        e.res  = exp;
        e.at   = cyc + lat;
        e.name = name;
        sb.push_back(e);
        #1 chk({name, "_busy_issue"}, {63'd0, busy}, 64'd1);
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = ~signed_div;
            #1;
            if (i < lat) begin
                if (busy !== 1'b1) bad++;
            end else begin
                chk({name, "_busy_ready"}, {63'd0, busy}, 64'd0);
            end
        end
        start = 1'b0;
        chk({name, "_busy_hold"}, 64'(bad), 64'd0);
        last_res = exp;
    endtask

    initial begin
        int n;
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        annul      = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        last_res   = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_result", result, 64'd0);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        resetn = 1'b1;

        @(negedge clk) run_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        @(negedge clk) run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        @(negedge clk) run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        @(negedge clk) run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        @(negedge clk) run_op("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33);
        @(negedge clk) run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);
        @(negedge clk) run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
        @(negedge clk) run_op("divu_3_5", 1'b0, 32'd3, 32'd5, {32'd3, 32'd0}, 33);

        // annul at cycle 10 of a 100/7, new 200/3 issued at cycle 12
        @(negedge clk);
        n          = cyc;
        start      = 1'b1;
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        for (int i = 1; i <= 10; i++) @(negedge clk);
        start = 1'b0;
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        #1;
        chk("annul_result_kept", result, last_res);
        chk("annul_idle_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("annul_restart_cycle", 64'(cyc - n), 64'd12);
        run_op("divu_200_3", 1'b0, 32'd200, 32'd3, {32'd2, 32'd66}, 33);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b1;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        for (int i = 1; i <= 15; i++) @(negedge clk);
        start  = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_mid_result", result, 64'd0);
        chk("rst_mid_ready", {63'd0, ready}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk) run_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);

        repeat (3) @(negedge clk);
        chk("pending_ready", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage, downstream of the ALU decoder.
- Services DIV_CONTROL and DIVU_CONTROL, and writes {remainder, quotient} toward the HI/LO registers.
- Holds the pipeline via busy while iterating.
- Implements radix-2 restoring division, one quotient bit per cycle.

Parameters:
WIDTH, 32, operand width. Quotient/remainder are WIDTH bits; the iteration count equals WIDTH.

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  level request from EX: high while a DIV/DIVU is in EX and not flushed
signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start
opdata1  in  WIDTH  dividend (rs); sampled with start
opdata2  in  WIDTH  divisor (rt); sampled with start
annul  in  1  flush/exception cancel; abandons any operation in flight
result  out  2*WIDTH  {remainder, quotient} = {HI, LO}
ready  out  1  one-cycle pulse: result valid this cycle
busy  out  1  stall request to hazard unit

Behaviour:
- Reset (resetn=0, async): state=IDLE; result=0, ready=0, busy=0; all internal registers=0.
- FSM states: IDLE, DIVZERO, BUSY, DONE. Encodings live in defines2.vh.
- IDLE:
  - start=1, annul=0, opdata2!=0 -> BUSY. Latch |dividend|, |divisor|, sign flags (signed_div only); clear iteration counter.
  - start=1, annul=0, opdata2==0 -> DIVZERO.
  - Otherwise stay in IDLE.
- DIVZERO: one cycle, then DONE with result=0. Division by zero is architecturally undefined; the 0 value is fixed for determinism.
- BUSY:
  - Each cycle: shift {partial remainder, dividend} left 1.
  - Trial-subtract the divisor (WIDTH+1 bits). If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Counter increments; after WIDTH iterations -> DONE.
- DONE:
  - ready=1 for exactly this cycle; result updated.
  - Signed fix-up: quotient negated if dividend sign != divisor sign; remainder negated if dividend negative.
  - Next state IDLE unconditionally; start still high in this cycle is ignored.
- busy:
  - 1 in DIVZERO and BUSY.
  - 1 in IDLE when start=1 and annul=0 (combinational, so the issuing cycle stalls).
  - 0 in DONE, so the pipeline advances in the ready cycle.
- Latency: start seen in cycle 0 -> ready in cycle WIDTH+1 (33). Divide-by-zero -> ready in cycle 2.
- result holds its last value until the next DONE; it is not cleared on IDLE.
- annul:
  - Any state -> IDLE on the next edge; ready never asserts for the cancelled op; result unchanged.
  - annul takes priority over start in the same cycle.
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, no trap. This falls out naturally from unsigned magnitudes with WIDTH-bit wrap.
- Operand changes on opdata1/opdata2 after acceptance have no effect.
- Exactly one ready pulse per accepted, unannulled start.

Decomposition:
- defines2.vh additions: state encodings DIV_IDLE, DIV_BYZERO, DIV_BUSY, DIV_DONE (2 bits).
- DIV_CONTROL and DIVU_CONTROL are reused from the existing file; the EX stage derives start and signed_div from alucontrol.
- No sub-module. Negation/absolute-value helpers are local functions inside div_unit.

Test Plan:
- Unsigned: start, DIVU, 100/7 -> ready exactly at cycle 33, result={32'd2, 32'd14}; busy high cycles 0-32, low at 33.
- Signed: DIV, 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
- Boundary:
  - DIV 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
  - DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
  - DIVU 3/5 -> {3, 0}.
- Divide by zero: DIVU 5/0 -> ready at cycle 2, result 64'h0; busy high cycles 0-1.
- Annul: start 100/7; assert annul at cycle 10 -> IDLE next edge, no ready, result keeps prior value. A new start at cycle 12 (200/3) -> ready at cycle 45, result {2, 66}.
- Reset mid-op: drop resetn at cycle 15 -> result=0, ready=0, busy=0 immediately (async). After release, a new op completes normally in 33 cycles.
